regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 65 ++++++
 tb/tb_regfile_mp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with reset/request-driven clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    clear_req,
    output logic                    busy
);
    localparam int DEPTH = 2**ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic wr_ok, byp_ok;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= ADDR_W'(1);
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end
    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (state == CLEAR) begin
            idx_next   = idx + 1'b1;
            state_next = &idx ? IDLE : CLEAR;
        end else if (clear_req) begin
            state_next = CLEAR;
            idx_next   = ADDR_W'(1);
        end
    end
    assign busy   = (state == CLEAR);
    assign byp_ok = BYP && !busy && wr_en && |wr_addr;
    // a write colliding with a clear request is dropped so the clear wins
    assign wr_ok  = !rst && !busy && wr_en && |wr_addr && !clear_req;
    always_ff @(posedge clk) begin
        if (busy)
            mem[idx] <= '0;
        else if (wr_ok)
            mem[wr_addr] <= wr_data;
    end
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] = (busy || a == '0) ? '0 :
                                             (byp_ok && wr_addr == a) ? wr_data : mem[a];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a behavioural model.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, wr_en, clear_req, busy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [DEPTH];
    int busy_left;
    int bc;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .busy(busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (busy_left > 0 || a == 0) return '0;
        if (BYP && wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
        return model[a];
    endfunction

    // Clearing is modelled as instantaneous: reads are zero and writes dropped while busy anyway.
    task automatic model_edge();
        if (rst || (busy_left == 0 && clear_req)) begin
            foreach (model[i]) model[i] = '0;
            busy_left = DEPTH - 1;
        end else if (busy_left > 0)
            busy_left--;
        else if (wr_en && wr_addr != 0)
            model[wr_addr] = wr_data;
    endtask

    task automatic step();
        @(negedge clk);
        chk("busy", DW'(busy), DW'(busy_left > 0));
        for (int k = 0; k < NR; k++)
            chk($sformatf("rd%0d@%0d", k, rd_addr[k*AW +: AW]), rd_data[k*DW +: DW], exp_rd(rd_addr[k*AW +: AW]));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, a1, a2, a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic rand_rd();
        rd_addr = NR*AW'($urandom);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic count_busy(input string tag, input bit pulse_clear);
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            rand_rd();
            clear_req = pulse_clear && bc == 5;
            wr_en = (bc == 2); wr_addr = 3; wr_data = 32'hFF;
            step();
            bc++;
        end
        clear_req = 1'b0; wr_en = 1'b0;
        chk(tag, DW'(bc), DW'(DEPTH - 1));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; clear_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        @(posedge clk);
        model_edge();
        #1;
        chk("rst_busy", DW'(busy), 1);
        chk("rst_rd0", rd_data[0 +: DW], 0);
        rst = 1'b0;
        count_busy("reset_len", 1'b0);

        set_rd(5, 5, 0, 0);
        wr(5, 32'hDEADBEEF);
        chk("r5", rd_data[0 +: DW], 32'hDEADBEEF);

        set_rd(0, 0, 0, 0);
        wr(0, 32'h12345678);
        for (int k = 0; k < NR; k++) chk($sformatf("r0_p%0d", k), rd_data[k*DW +: DW], 0);

        wr(7, 32'h11111111);
        set_rd(0, 7, 0, 0);
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
        #1;
        chk("r7_same", rd_data[DW +: DW], BYP ? 32'hA5A5A5A5 : 32'h11111111);
        step();
        wr_en = 1'b0;
        #1;
        chk("r7_next", rd_data[DW +: DW], 32'hA5A5A5A5);

        for (int a = 1; a < DEPTH; a++) wr(AW'(a), DW'(a));
        set_rd(1, 3, 17, 31);
        #1;
        chk("fill3", rd_data[DW +: DW], 3);
        chk("fill31", rd_data[3*DW +: DW], 31);
        clear_req = 1'b1;
        step();
        count_busy("clear_len", 1'b0);
        for (int a = 1; a < DEPTH; a++) begin
            set_rd(AW'(a), AW'(a), AW'(a), AW'(a));
            #1;
            chk($sformatf("cleared_r%0d", a), rd_data[2*DW +: DW], 0);
        end

        wr(9, 32'h99);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (10) begin rand_rd(); step(); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("rst_mid_len", 1'b1);

        for (int a = 1; a <= 4; a++) wr(AW'(a), DW'(a));
        set_rd(1, 2, 3, 4);
        #1;
        for (int k = 0; k < NR; k++) chk($sformatf("quad_p%0d", k), rd_data[k*DW +: DW], DW'(k + 1));

        repeat (600) begin
            rand_rd();
            wr_en = $urandom_range(0, 1) == 1;
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            clear_req = $urandom_range(0, 39) == 0;
            rst = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 1'b0; clear_req = 1'b0; wr_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
